// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu-level stage sequencer: FSM states, mode
// selectors and canonical stage indices.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } seq_state_e;

  localparam int unsigned MODE_SEQ  = 0;
  localparam int unsigned MODE_PIPE = 1;

  localparam int unsigned STG_IF = 0;
  localparam int unsigned STG_ID = 1;
  localparam int unsigned STG_EX = 2;
  localparam int unsigned STG_WB = 3;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter: increments on inc_i, wraps modulo 2^W.
module event_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Single-clock stage sequencer: per-stage enable strobes with ready/stall handshake,
// run/halt control, sequential or overlapped issue, and busy/retire counters.
module stage_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned MODE       = MODE_SEQ,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic                  halt_req_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [NUM_STAGES-1:0] stage_first_o,
  output logic                  retire_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic [CNT_W-1:0]      cycle_count_o,
  output logic [CNT_W-1:0]      retire_count_o
);

  localparam logic [NUM_STAGES-1:0] FirstStage = NUM_STAGES'(1) << STG_IF;

  seq_state_e state_q, state_d;
  logic       halt_pending_q, halt_pending_d;
  logic       fresh_q, fresh_d;
  logic       busy;
  logic       start;
  logic       adv;
  logic       drain_done;
  logic       retire;

  assign busy  = (state_q == StRun) || (state_q == StDrain);
  // Launch from IDLE on run; resume from HALTED only when no halt is being requested.
  assign start = run_i & ((state_q == StIdle) | ((state_q == StHalted) & ~halt_req_i));

  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StRun;
      end
      StRun: begin
        if (halt_req_i) begin
          halt_pending_d = 1'b1;
          state_d        = drain_done ? StHalted : StDrain;
        end
      end
      StDrain: begin
        if (drain_done && halt_pending_q) state_d = StHalted;
      end
      StHalted: begin
        if (start) begin
          state_d        = StRun;
          halt_pending_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    fresh_d = adv | start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      halt_pending_q <= 1'b0;
      fresh_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      fresh_q        <= fresh_d;
    end
  end

  if (MODE == MODE_SEQ) begin : g_seq
    logic [NUM_STAGES-1:0] cur_q, cur_d;

    assign stage_en_o = busy ? cur_q : '0;
    assign adv        = |(stage_en_o & stage_ready_i);
    assign retire     = stage_en_o[NUM_STAGES-1] & stage_ready_i[NUM_STAGES-1];
    // Only the last stage's completion leaves nothing in flight.
    assign drain_done = retire;

    always_comb begin
      cur_d = cur_q;
      if (start)    cur_d = FirstStage;
      else if (adv) cur_d = {cur_q[NUM_STAGES-2:0], cur_q[NUM_STAGES-1]};
    end

    always_ff @(posedge clk) begin
      if (reset) cur_q <= '0;
      else       cur_q <= cur_d;
    end
  end else begin : g_pipe
    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic                  inject;
    logic                  advance;

    // A halt request suppresses injection on the very edge it leaves RUN.
    assign inject     = (state_q == StRun) & ~halt_req_i;
    assign advance    = &(stage_ready_i | ~valid_q);
    assign stage_en_o = valid_q;
    assign adv        = busy & advance;
    assign retire     = advance & valid_q[NUM_STAGES-1];
    assign drain_done = (valid_d == '0);

    always_comb begin
      valid_d = valid_q;
      if (start)    valid_d = FirstStage;
      else if (adv) valid_d = {valid_q[NUM_STAGES-2:0], inject};
    end

    always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
    end
  end

  assign stage_first_o = stage_en_o & {NUM_STAGES{fresh_q}};
  assign retire_o      = retire;
  assign busy_o        = busy;
  assign halted_o      = (state_q == StHalted);

  event_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (busy),
    .count_o(cycle_count_o)
  );

  event_counter #(
    .W(CNT_W)
  ) u_retire_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (retire),
    .count_o(retire_count_o)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a sequential instance with 4-bit counters
// and an overlapped instance, each driven through run/stall/halt/reset scenarios.
module tb_stage_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_reset, s_run, s_halt;
  logic [3:0] s_ready, s_en, s_first;
  logic       s_retire, s_busy, s_halted;
  logic [3:0] s_cyc, s_ret;

  logic        p_reset, p_run, p_halt;
  logic [3:0]  p_ready, p_en, p_first;
  logic        p_retire, p_busy, p_halted;
  logic [31:0] p_cyc, p_ret;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(
    .NUM_STAGES(4),
    .MODE      (MODE_SEQ),
    .CNT_W     (4)
  ) dut_seq (
    .clk           (clk),
    .reset         (s_reset),
    .run_i         (s_run),
    .halt_req_i    (s_halt),
    .stage_ready_i (s_ready),
    .stage_en_o    (s_en),
    .stage_first_o (s_first),
    .retire_o      (s_retire),
    .busy_o        (s_busy),
    .halted_o      (s_halted),
    .cycle_count_o (s_cyc),
    .retire_count_o(s_ret)
  );

  stage_sequencer #(
    .NUM_STAGES(4),
    .MODE      (MODE_PIPE),
    .CNT_W     (32)
  ) dut_pipe (
    .clk           (clk),
    .reset         (p_reset),
    .run_i         (p_run),
    .halt_req_i    (p_halt),
    .stage_ready_i (p_ready),
    .stage_en_o    (p_en),
    .stage_first_o (p_first),
    .retire_o      (p_retire),
    .busy_o        (p_busy),
    .halted_o      (p_halted),
    .cycle_count_o (p_cyc),
    .retire_count_o(p_ret)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fill [6];
    int drain [3];
    fill  = '{1, 3, 7, 15, 15, 15};
    drain = '{14, 12, 8};

    s_reset = 1'b1; s_run = 1'b0; s_halt = 1'b0; s_ready = 4'b1111;
    p_reset = 1'b1; p_run = 1'b0; p_halt = 1'b0; p_ready = 4'b1111;
    step();
    step();
    #1;
    check_eq("s_rst_en", 32'(s_en), 0);
    check_eq("s_rst_busy", 32'(s_busy), 0);
    check_eq("s_rst_halted", 32'(s_halted), 0);
    check_eq("s_rst_cyc", 32'(s_cyc), 0);
    check_eq("p_rst_en", 32'(p_en), 0);
    check_eq("p_rst_ret", p_ret, 0);
    s_reset = 1'b0;
    p_reset = 1'b0;
    step();

    // Sequential: run pulse, all stages ready.
    s_run = 1'b1;
    #1;
    check_eq("s_idle_en", 32'(s_en), 0);
    step();
    s_run = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_eq("s_walk_en", 32'(s_en), 1 << (k % 4));
      check_eq("s_walk_first", 32'(s_first), 1 << (k % 4));
      check_eq("s_walk_retire", 32'(s_retire), ((k % 4) == 3) ? 1 : 0);
      step();
    end
    check_eq("s_walk_cyc", 32'(s_cyc), 12);
    check_eq("s_walk_ret", 32'(s_ret), 3);

    // Sequential: stage 2 stalled for 5 cycles.
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("s_pre_stall_en", 32'(s_en), 1 << k);
      step();
    end
    s_ready = 4'b1011;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq("s_stall_en", 32'(s_en), 4);
      check_eq("s_stall_first", 32'(s_first), (j == 0) ? 4 : 0);
      check_eq("s_stall_retire", 32'(s_retire), 0);
      step();
    end
    s_ready = 4'b1111;
    #1;
    check_eq("s_release_en", 32'(s_en), 4);
    check_eq("s_release_first", 32'(s_first), 0);
    step();
    #1;
    check_eq("s_after_en", 32'(s_en), 8);
    check_eq("s_after_first", 32'(s_first), 8);
    check_eq("s_after_retire", 32'(s_retire), 1);
    step();
    check_eq("s_stall_ret", 32'(s_ret), 4);
    check_eq("s_stall_cyc", 32'(s_cyc), 21 % 16);

    // Sequential: halt while stage 1 is active.
    #1;
    check_eq("s_h0_en", 32'(s_en), 1);
    step();
    s_halt = 1'b1;
    #1;
    check_eq("s_h1_en", 32'(s_en), 2);
    step();
    s_halt = 1'b0;
    #1;
    check_eq("s_h2_busy", 32'(s_busy), 1);
    check_eq("s_h2_en", 32'(s_en), 4);
    check_eq("s_h2_retire", 32'(s_retire), 0);
    step();
    #1;
    check_eq("s_h3_en", 32'(s_en), 8);
    check_eq("s_h3_retire", 32'(s_retire), 1);
    step();
    #1;
    check_eq("s_halted", 32'(s_halted), 1);
    check_eq("s_halted_busy", 32'(s_busy), 0);
    check_eq("s_halted_en", 32'(s_en), 0);
    check_eq("s_halted_ret", 32'(s_ret), 5);
    s_run = 1'b1;
    s_halt = 1'b1;
    step();
    #1;
    check_eq("s_hold_halted", 32'(s_halted), 1);
    s_halt = 1'b0;
    step();
    s_run = 1'b0;
    #1;
    check_eq("s_resume_en", 32'(s_en), 1);
    check_eq("s_resume_first", 32'(s_first), 1);
    check_eq("s_resume_halted", 32'(s_halted), 0);
    step();

    // Sequential: reset mid-run.
    s_reset = 1'b1;
    step();
    #1;
    check_eq("s_mrst_en", 32'(s_en), 0);
    check_eq("s_mrst_first", 32'(s_first), 0);
    check_eq("s_mrst_busy", 32'(s_busy), 0);
    check_eq("s_mrst_halted", 32'(s_halted), 0);
    check_eq("s_mrst_retire", 32'(s_retire), 0);
    check_eq("s_mrst_cyc", 32'(s_cyc), 0);
    check_eq("s_mrst_ret", 32'(s_ret), 0);
    s_reset = 1'b0;
    step();

    // Sequential: 4-bit retire counter wraps after 16 retires.
    s_run = 1'b1;
    step();
    s_run = 1'b0;
    for (int k = 0; k < 63; k++) step();
    check_eq("s_wrap_ret15", 32'(s_ret), 15);
    step();
    check_eq("s_wrap_ret0", 32'(s_ret), 0);
    check_eq("s_wrap_cyc0", 32'(s_cyc), 0);

    // Overlapped: fill with all stages ready.
    p_run = 1'b1;
    #1;
    check_eq("p_idle_en", 32'(p_en), 0);
    step();
    p_run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("p_fill_en", 32'(p_en), fill[k]);
      check_eq("p_fill_first", 32'(p_first), fill[k]);
      check_eq("p_fill_retire", 32'(p_retire), (k >= 3) ? 1 : 0);
      step();
    end

    // Overlapped: stage 1 not ready freezes the whole chain.
    p_ready = 4'b1101;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_eq("p_stall_en", 32'(p_en), 15);
      check_eq("p_stall_first", 32'(p_first), (s == 0) ? 15 : 0);
      check_eq("p_stall_retire", 32'(p_retire), 0);
      step();
    end
    check_eq("p_stall_cyc", p_cyc, 9);
    check_eq("p_stall_ret", p_ret, 3);

    // Overlapped: halt coincident with a retire, then drain.
    p_ready = 4'b1111;
    p_halt = 1'b1;
    #1;
    check_eq("p_halt_retire", 32'(p_retire), 1);
    check_eq("p_halt_first", 32'(p_first), 0);
    step();
    p_halt = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #1;
      check_eq("p_drain_en", 32'(p_en), drain[d]);
      check_eq("p_drain_retire", 32'(p_retire), 1);
      check_eq("p_drain_busy", 32'(p_busy), 1);
      step();
    end
    #1;
    check_eq("p_halted", 32'(p_halted), 1);
    check_eq("p_halted_en", 32'(p_en), 0);
    check_eq("p_halted_busy", 32'(p_busy), 0);
    check_eq("p_halted_ret", p_ret, 7);
    check_eq("p_halted_cyc", p_cyc, 13);
    p_run = 1'b1;
    step();
    p_run = 1'b0;
    #1;
    check_eq("p_resume_en", 32'(p_en), 1);
    check_eq("p_resume_first", 32'(p_first), 1);
    step();

    // Overlapped: reset mid-run.
    p_reset = 1'b1;
    step();
    #1;
    check_eq("p_mrst_en", 32'(p_en), 0);
    check_eq("p_mrst_first", 32'(p_first), 0);
    check_eq("p_mrst_busy", 32'(p_busy), 0);
    check_eq("p_mrst_halted", 32'(p_halted), 0);
    check_eq("p_mrst_retire", 32'(p_retire), 0);
    check_eq("p_mrst_cyc", p_cyc, 0);
    check_eq("p_mrst_ret", p_ret, 0);
    p_reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
